// File: rtl/softmax_fifo_ctrl.sv
// Softmax pass sequencer: fills the shared vector fifo while tracking the signed max, then replays it.
// Fifo enables are combinational; out_valid lags fifo_rd_en by one cycle and holds while out_ready is low.
module softmax_fifo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 32,
  parameter int MAX_LEN    = FIFO_DEPTH - 1,
  parameter int LEN_W      = $clog2(MAX_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_W-1:0]      vec_len,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_din,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_full,
  input  logic                  fifo_empty,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [DATA_WIDTH-1:0] out_max,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN, S_DONE} state_t;

  localparam logic [LEN_W:0]   LEN_LIMIT = (LEN_W + 1)'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE       = LEN_W'(1);

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] wr_cnt;
  logic [LEN_W-1:0] rd_cnt;
  logic [LEN_W-1:0] out_cnt;
  logic             start_ok;
  logic             start_bad;
  logic             out_fire;
  logic             last_wr;
  logic             last_out;

  // The extra top bit keeps the upper bound meaningful for any LEN_W/MAX_LEN pairing.
  assign start_ok  = (state == S_IDLE) && start && (vec_len != '0) &&
                     ({1'b0, vec_len} <= LEN_LIMIT);
  assign start_bad = (state == S_IDLE) && start && !start_ok;

  assign out_fire = out_valid && out_ready;
  assign last_wr  = fifo_wr_en && (wr_cnt == (len_q - ONE));
  assign last_out = out_fire && (out_cnt == (len_q - ONE));

  assign fifo_din = in_data;
  assign out_data = fifo_dout;
  assign out_last = out_valid && (out_cnt == (len_q - ONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok) state_nxt = S_FILL;
      S_FILL:  if (last_wr)  state_nxt = S_DRAIN;
      S_DRAIN: if (last_out) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = 1'b0;
    fifo_wr_en = 1'b0;
    fifo_rd_en = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      S_IDLE: busy = 1'b0;
      S_FILL: begin
        in_ready   = !fifo_full;
        fifo_wr_en = in_valid && !fifo_full;
      end
      // A read is only issued when the output register is free or being emptied this cycle.
      S_DRAIN: fifo_rd_en = (rd_cnt < len_q) && !fifo_empty && (!out_valid || out_ready);
      S_DONE:  done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q     <= '0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      out_cnt   <= '0;
      out_max   <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= start_bad;
      if (start_ok) begin
        len_q   <= vec_len;
        wr_cnt  <= '0;
        rd_cnt  <= '0;
        out_cnt <= '0;
      end
      if (fifo_wr_en) begin
        wr_cnt <= wr_cnt + ONE;
        if ((wr_cnt == '0) || ($signed(in_data) > $signed(out_max))) begin
          out_max <= in_data;
        end
      end
      if (fifo_rd_en) begin
        rd_cnt <= rd_cnt + ONE;
      end
      if (fifo_rd_en) begin
        out_valid <= 1'b1;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
      if (out_fire) begin
        out_cnt <= out_cnt + ONE;
      end
    end
  end

endmodule

// File: tb/tb_softmax_fifo_ctrl.sv
// Directed bench for softmax_fifo_ctrl with a behavioural registered-output fifo attached.
module tb_softmax_fifo_ctrl;
  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int MAXL  = DEPTH - 1;
  localparam int LW    = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] vec_len = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, fifo_wr_en, fifo_rd_en, fifo_full, fifo_empty;
  logic [DW-1:0] fifo_din, fifo_dout, out_data, out_max;
  logic          out_valid, out_last, busy, done, err;
  logic          out_ready = 1'b0;
  logic          force_full = 1'b0;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  softmax_fifo_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_len(vec_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .out_valid(out_valid), .out_data(out_data), .out_max(out_max),
    .out_last(out_last), .out_ready(out_ready), .busy(busy), .done(done), .err(err)
  );

  // Fifo model: capacity DEPTH-1, read data registered one cycle after rd_en.
  logic [DW-1:0] fmem [DEPTH];
  logic [5:0]    fcnt;
  logic [4:0]    fwp, frp;
  logic          f_wok, f_rok;
  assign f_wok      = fifo_wr_en && (fcnt != 6'(DEPTH - 1));
  assign f_rok      = fifo_rd_en && (fcnt != 6'd0);
  assign fifo_full  = (fcnt == 6'(DEPTH - 1)) || force_full;
  assign fifo_empty = (fcnt == 6'd0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt <= '0; fwp <= '0; frp <= '0; fifo_dout <= '0;
    end else begin
      if (f_wok) begin fmem[fwp] <= fifo_din; fwp <= fwp + 5'd1; end
      if (f_rok) begin fifo_dout <= fmem[frp]; frp <= frp + 5'd1; end
      fcnt <= fcnt + 6'(f_wok) - 6'(f_rok);
    end
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, $signed(act), $signed(exp));
    end
  endtask

  // Per-cycle vector: inputs, then expected {in_ready, wr_en, rd_en, out_valid, out_last, busy, done, err}.
  typedef struct {
    logic          st;
    logic [LW-1:0] vl;
    logic          iv;
    logic [DW-1:0] id;
    logic          ordy;
    logic [7:0]    e;
    logic [DW-1:0] od;
    logic          cm;
    logic [DW-1:0] mx;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input bit st, input int vl, input bit iv, input int id, input bit ordy,
                              input bit [7:0] e, input int od, input bit cm, input int mx);
    vec_t v;
    v.st = st; v.vl = LW'(vl); v.iv = iv; v.id = DW'(id); v.ordy = ordy;
    v.e = e; v.od = DW'(od); v.cm = cm; v.mx = DW'(mx);
    tbl.push_back(v);
  endfunction

  logic [DW-1:0] din_q[$];
  logic [DW-1:0] dout_q[$];
  int            last_at;

  task automatic start_pass(input int len);
    start = 1'b1; vec_len = LW'(len);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_fill(input bit gaps, input bit poke);
    int i = 0;
    int cyc = 0;
    while (i < din_q.size() && cyc < 500) begin
      in_valid   = gaps ? (cyc % 3 != 2) : 1'b1;
      in_data    = din_q[i];
      start      = poke;
      vec_len    = LW'(1);
      force_full = poke && (cyc == 1 || cyc == 2);
      #1;
      chk($sformatf("fill_rdy%0d", cyc), in_ready, !force_full);
      chk($sformatf("fill_wr%0d", cyc), fifo_wr_en, in_valid && !force_full);
      if (in_valid && in_ready) i++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; start = 1'b0; force_full = 1'b0;
    if (i < din_q.size()) chk("fill_timeout", 0, 1);
  endtask

  task automatic do_drain(input logic [DW-1:0] exp_max, input bit poke);
    int cyc = 0;
    bit seen = 0;
    dout_q.delete();
    last_at = -1;
    while (!seen && cyc < 500) begin
      out_ready = 1'b1;
      start     = poke;
      vec_len   = LW'(1);
      #1;
      if (poke) chk("poke_err", err, 1'b0);
      if (out_valid && out_ready) begin
        dout_q.push_back(out_data);
        if (out_last) last_at = dout_q.size();
        chk("max_hold", out_max, exp_max);
      end
      if (done) seen = 1;
      else chk("drain_busy", busy, 1'b1);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (!seen) chk("drain_timeout", 0, 1);
  endtask

  task automatic check_pass(input string nm);
    chk({nm, "_count"}, dout_q.size(), din_q.size());
    for (int i = 0; i < din_q.size() && i < dout_q.size(); i++)
      chk($sformatf("%s_d%0d", nm, i), dout_q[i], din_q[i]);
    chk({nm, "_last"}, last_at, din_q.size());
  endtask

  initial begin
    // T1: len 4, out_ready high
    add(1,4,0,0,1,   8'b00000000, 0,1,0);
    add(0,0,1,3,1,   8'b11000100, 0,1,0);
    add(0,0,1,-7,1,  8'b11000100, 0,1,3);
    add(0,0,1,10,1,  8'b11000100, 0,1,3);
    add(0,0,1,2,1,   8'b11000100, 0,1,10);
    add(0,0,0,0,1,   8'b00100100, 0,1,10);
    add(0,0,0,0,1,   8'b00110100, 3,1,10);
    add(0,0,0,0,1,   8'b00110100, -7,1,10);
    add(0,0,0,0,1,   8'b00110100, 10,1,10);
    add(0,0,0,0,1,   8'b00011100, 2,1,10);
    add(0,0,0,0,1,   8'b00000110, 0,1,10);
    add(0,0,0,0,1,   8'b00000000, 0,1,10);
    // T2: same data, out_ready 1,0,0,1,...
    add(1,4,0,0,1,   8'b00000000, 0,0,0);
    add(0,0,1,3,1,   8'b11000100, 0,0,0);
    add(0,0,1,-7,1,  8'b11000100, 0,1,3);
    add(0,0,1,10,1,  8'b11000100, 0,1,3);
    add(0,0,1,2,1,   8'b11000100, 0,1,10);
    add(0,0,0,0,1,   8'b00100100, 0,1,10);
    add(0,0,0,0,0,   8'b00010100, 3,1,10);
    add(0,0,0,0,0,   8'b00010100, 3,1,10);
    add(0,0,0,0,1,   8'b00110100, 3,1,10);
    add(0,0,0,0,0,   8'b00010100, -7,1,10);
    add(0,0,0,0,0,   8'b00010100, -7,1,10);
    add(0,0,0,0,1,   8'b00110100, -7,1,10);
    add(0,0,0,0,0,   8'b00010100, 10,1,10);
    add(0,0,0,0,0,   8'b00010100, 10,1,10);
    add(0,0,0,0,1,   8'b00110100, 10,1,10);
    add(0,0,0,0,0,   8'b00011100, 2,1,10);
    add(0,0,0,0,0,   8'b00011100, 2,1,10);
    add(0,0,0,0,1,   8'b00011100, 2,1,10);
    add(0,0,0,0,1,   8'b00000110, 0,1,10);
    add(0,0,0,0,1,   8'b00000000, 0,1,10);
    // T3: illegal lengths with in_valid high in IDLE
    add(1,0,1,55,0,        8'b00000000, 0,0,0);
    add(0,0,1,55,0,        8'b00000001, 0,0,0);
    add(1,MAXL+1,1,55,0,   8'b00000000, 0,0,0);
    add(0,0,1,55,0,        8'b00000001, 0,0,0);
    add(0,0,0,0,0,         8'b00000000, 0,0,0);

    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovalid", out_valid, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_max", out_max, '0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      start = tbl[i].st; vec_len = tbl[i].vl; in_valid = tbl[i].iv;
      in_data = tbl[i].id; out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("v%0d_in_ready", i), in_ready, tbl[i].e[7]);
      chk($sformatf("v%0d_wr_en", i), fifo_wr_en, tbl[i].e[6]);
      chk($sformatf("v%0d_rd_en", i), fifo_rd_en, tbl[i].e[5]);
      chk($sformatf("v%0d_out_valid", i), out_valid, tbl[i].e[4]);
      chk($sformatf("v%0d_out_last", i), out_last, tbl[i].e[3]);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].e[2]);
      chk($sformatf("v%0d_done", i), done, tbl[i].e[1]);
      chk($sformatf("v%0d_err", i), err, tbl[i].e[0]);
      if (tbl[i].e[6]) chk($sformatf("v%0d_fifo_din", i), fifo_din, tbl[i].id);
      if (tbl[i].e[4]) chk($sformatf("v%0d_out_data", i), out_data, tbl[i].od);
      if (tbl[i].cm) chk($sformatf("v%0d_out_max", i), out_max, tbl[i].mx);
      @(negedge clk);
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

    // T4: full-length negative vector with input gaps
    din_q.delete();
    din_q.push_back(-1000);
    for (int i = 1; i < MAXL - 1; i++) din_q.push_back(DW'(-2 - ((i * 7) % 20)));
    din_q.push_back(-1);
    start_pass(MAXL);
    do_fill(1'b1, 1'b0);
    do_drain(-1, 1'b0);
    check_pass("t4");

    // T5: start poked during FILL and DRAIN, plus a fifo_full stall
    din_q.delete();
    din_q.push_back(5); din_q.push_back(-1); din_q.push_back(8);
    start_pass(3);
    do_fill(1'b0, 1'b1);
    do_drain(8, 1'b1);
    check_pass("t5");

    // T6: reset after two of four outputs
    din_q.delete();
    din_q.push_back(1); din_q.push_back(2); din_q.push_back(3); din_q.push_back(4);
    start_pass(4);
    do_fill(1'b0, 1'b0);
    begin
      int hs = 0;
      int cyc = 0;
      while (hs < 2 && cyc < 100) begin
        out_ready = 1'b1;
        #1;
        if (out_valid) hs++;
        @(negedge clk);
        cyc++;
      end
      if (hs < 2) chk("t6_timeout", 0, 1);
    end
    rst_n = 1'b0;
    #1;
    chk("t6_ovalid", out_valid, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_rd_en", fifo_rd_en, 1'b0);
    chk("t6_in_ready", in_ready, 1'b0);
    chk("t6_last", out_last, 1'b0);
    chk("t6_done", done, 1'b0);
    chk("t6_max", out_max, '0);
    chk("t6_empty", fifo_empty, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    din_q.delete();
    din_q.push_back(9); din_q.push_back(8); din_q.push_back(7);
    start_pass(3);
    do_fill(1'b0, 1'b0);
    do_drain(9, 1'b0);
    check_pass("t6b");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
